coreport_ex: RTL and testbench

Wishbone B3 classic GPIO port peripheral, WIDTH pins wide, with a registered acknowledge. It adds the following: a metastability synchroniser on inputs, per-pin edge or level interrupts with polarity and any-edge select, write-1-to-clear interrupt flags, and atomic set/clear/toggle output registers. It sits on the peripheral Wishbone bus and drives one bank of bidirectional pins, with a single interrupt output to the interrupt controller.

---
 rtl/coreport_ex_if.sv | 27 ++
 rtl/coreport_ex.sv | 152 +++++++++++++++
 tb/tb_coreport_ex.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/coreport_ex_if.sv
// Wishbone B3 classic slave bus bundle for the coreport_ex GPIO port.
// The master modport is the bus side; the slave modport is the peripheral side.
interface coreport_ex_if #(
  parameter int unsigned WIDTH = 8
);
  logic [31:0]      wb_adr_i;
  logic [WIDTH-1:0] wb_dat_i;
  logic             wb_we_i;
  logic             wb_cyc_i;
  logic             wb_stb_i;
  logic [2:0]       wb_cti_i;
  logic [1:0]       wb_bte_i;
  logic [WIDTH-1:0] wb_dat_o;
  logic             wb_ack_o;
  logic             wb_err_o;
  logic             wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/coreport_ex.sv
// Wishbone GPIO port: synchronised inputs, edge/level interrupts with W1C flags,
// atomic set/clear/toggle on the output data register, registered acknowledge.
module coreport_ex #(
  parameter int unsigned      WIDTH         = 8,
  parameter logic [WIDTH-1:0] INITIAL_DDR   = '0,
  parameter logic [WIDTH-1:0] INITIAL_DATAR = '0,
  parameter int unsigned      SYNC_STAGES   = 2
) (
  input  logic              wb_clk,
  input  logic              wb_rst,
  coreport_ex_if.slave      wb,
  inout  wire  [WIDTH-1:0]  gpio_io,
  output logic              irq
);

  localparam int unsigned ARM_MAX = SYNC_STAGES + 1;
  localparam int unsigned ARM_W   = $clog2(ARM_MAX + 1);

  localparam logic [7:0] ADR_DATAR = 8'h00;
  localparam logic [7:0] ADR_DDR   = 8'h04;
  localparam logic [7:0] ADR_IMR   = 8'h08;
  localparam logic [7:0] ADR_IFR   = 8'h0C;
  localparam logic [7:0] ADR_ITYPE = 8'h10;
  localparam logic [7:0] ADR_IPOL  = 8'h14;
  localparam logic [7:0] ADR_IANY  = 8'h18;
  localparam logic [7:0] ADR_INV   = 8'h1C;
  localparam logic [7:0] ADR_SET   = 8'h20;
  localparam logic [7:0] ADR_CLR   = 8'h24;
  localparam logic [7:0] ADR_TGL   = 8'h28;

  logic [WIDTH-1:0] datar_q, datar_d, ddr_q, ddr_d, imr_q, imr_d, ifr_q, ifr_d;
  logic [WIDTH-1:0] itype_q, itype_d, ipol_q, ipol_d, iany_q, iany_d, inv_q, inv_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             ack_q, ack_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [ARM_W-1:0] arm_q, arm_d;

  logic [WIDTH-1:0] sync_in, rise, fall, edge_evt, level_evt, rdata, w1c, wdat;
  logic [7:0]       adr;
  logic             armed, acc;
  logic             unused_bus;

  assign adr   = wb.wb_adr_i[7:0];
  assign wdat  = wb.wb_dat_i;
  assign acc   = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  assign armed = (arm_q == ARM_W'(ARM_MAX));
  assign unused_bus = ^{wb.wb_adr_i[31:8], wb.wb_cti_i, wb.wb_bte_i};

  assign wb.wb_dat_o = dat_q;
  assign wb.wb_ack_o = ack_q;
  assign wb.wb_err_o = 1'b0;
  assign wb.wb_rty_o = 1'b0;

  // Pins drive only while an output and never during reset.
  for (genvar g = 0; g < WIDTH; g++) begin : g_pin
    assign gpio_io[g] = (ddr_q[g] && !wb_rst) ? (datar_q[g] ^ inv_q[g]) : 1'bz;
  end

  // Event detection works on raw synchronised input, gated by direction and arming.
  assign sync_in   = sync_q[SYNC_STAGES-1];
  assign rise      = sync_in & ~prev_q;
  assign fall      = ~sync_in & prev_q;
  assign edge_evt  = {WIDTH{armed}} & ~ddr_q & itype_q &
                     ((iany_q & (rise | fall)) | (~iany_q & ipol_q & rise) |
                      (~iany_q & ~ipol_q & fall));
  assign level_evt = {WIDTH{armed}} & ~ddr_q & ~itype_q & ~(sync_in ^ ipol_q);

  assign irq = |(ifr_q & imr_q);

  always_comb begin
    rdata = '0;
    unique case (adr)
      ADR_DATAR: rdata = sync_in ^ inv_q;
      ADR_DDR:   rdata = ddr_q;
      ADR_IMR:   rdata = imr_q;
      ADR_IFR:   rdata = ifr_q;
      ADR_ITYPE: rdata = itype_q;
      ADR_IPOL:  rdata = ipol_q;
      ADR_IANY:  rdata = iany_q;
      ADR_INV:   rdata = inv_q;
      default:   rdata = '0;
    endcase
  end

  always_comb begin
    datar_d = datar_q;
    ddr_d   = ddr_q;
    imr_d   = imr_q;
    itype_d = itype_q;
    ipol_d  = ipol_q;
    iany_d  = iany_q;
    inv_d   = inv_q;
    dat_d   = dat_q;
    w1c     = '0;
    ack_d   = acc;
    arm_d   = armed ? arm_q : arm_q + ARM_W'(1);
    if (acc && wb.wb_we_i) begin
      unique case (adr)
        ADR_DATAR: datar_d = wdat;
        ADR_DDR:   ddr_d   = wdat;
        ADR_IMR:   imr_d   = wdat;
        ADR_IFR:   w1c     = wdat;
        ADR_ITYPE: itype_d = wdat;
        ADR_IPOL:  ipol_d  = wdat;
        ADR_IANY:  iany_d  = wdat;
        ADR_INV:   inv_d   = wdat;
        ADR_SET:   datar_d = datar_q | wdat;
        ADR_CLR:   datar_d = datar_q & ~wdat;
        ADR_TGL:   datar_d = datar_q ^ wdat;
        default:   ;
      endcase
    end
    if (acc && !wb.wb_we_i) dat_d = rdata;
    // A new edge beats a same-cycle clear; a held level yields and re-sets next cycle.
    ifr_d = (ifr_q & ~w1c) | edge_evt | (level_evt & ~w1c);
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      datar_q <= INITIAL_DATAR;
      ddr_q   <= INITIAL_DDR;
      imr_q   <= '0;
      ifr_q   <= '0;
      itype_q <= '0;
      ipol_q  <= '0;
      iany_q  <= '0;
      inv_q   <= '0;
      dat_q   <= '0;
      ack_q   <= 1'b0;
      prev_q  <= '0;
      arm_q   <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      datar_q <= datar_d;
      ddr_q   <= ddr_d;
      imr_q   <= imr_d;
      ifr_q   <= ifr_d;
      itype_q <= itype_d;
      ipol_q  <= ipol_d;
      iany_q  <= iany_d;
      inv_q   <= inv_d;
      dat_q   <= dat_d;
      ack_q   <= ack_d;
      prev_q  <= sync_in;
      arm_q   <= arm_d;
      sync_q[0] <= gpio_io;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

endmodule

// File: tb/tb_coreport_ex.sv
// Directed bench for coreport_ex: read data is checked through an expected-value
// queue that is filled when a read is issued and drained when the ack arrives.
module tb_coreport_ex;

  localparam int unsigned WIDTH = 8;

  logic       wb_clk;
  logic       wb_rst;
  wire  [7:0] gpio;
  logic       irq;
  logic [7:0] tb_oe;
  logic [7:0] tb_val;
  logic       irq_at_ack;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] exp_q [$];
  string      tag_q [$];

  coreport_ex_if #(.WIDTH(WIDTH)) bus ();

  coreport_ex #(
    .WIDTH(WIDTH), .INITIAL_DDR(8'h0F), .INITIAL_DATAR(8'h05), .SYNC_STAGES(2)
  ) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wb(bus), .gpio_io(gpio), .irq(irq)
  );

  for (genvar g = 0; g < 8; g++) begin : g_drv
    assign gpio[g] = tb_oe[g] ? tb_val[g] : 1'bz;
  end

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int c);
    repeat (c) begin @(posedge wb_clk); #1; end
  endtask

  // One classic cycle, started at the current time (always 1 time unit after an edge).
  task automatic wb_access(input logic [7:0] adr, input logic we, input logic [7:0] wdat,
                           input string tag);
    int n = 0;
    bus.wb_adr_i = {24'h0, adr};
    bus.wb_we_i  = we;
    bus.wb_dat_i = wdat;
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    do begin @(posedge wb_clk); #1; n++; end while (!bus.wb_ack_o && n < 16);
    irq_at_ack = irq;
    chk({tag, "_ack"}, 32'(bus.wb_ack_o), 32'd1);
    chk({tag, "_lat"}, 32'(n), 32'd1);
    if (!we) chk(tag_q.pop_front(), 32'(bus.wb_dat_o), 32'(exp_q.pop_front()));
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    @(posedge wb_clk); #1;
    chk({tag, "_ackdrop"}, 32'(bus.wb_ack_o), 32'd0);
  endtask

  task automatic wb_write(input logic [7:0] adr, input logic [7:0] d, input string tag);
    wb_access(adr, 1'b1, d, tag);
  endtask

  task automatic wb_read(input logic [7:0] adr, input logic [7:0] exp, input string tag);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    wb_access(adr, 1'b0, 8'h00, tag);
  endtask

  initial begin
    wb_rst = 1'b1;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_we_i = 1'b0;
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_cti_i = '0; bus.wb_bte_i = '0;
    tb_oe = 8'hF0; tb_val = 8'hF0; irq_at_ack = 1'b0;
    cycles(3);

    // Release reset with a low pulse on pin4 while detection is still disarmed.
    wb_rst = 1'b0; tb_val[4] = 1'b0;
    cycles(1);
    tb_val[4] = 1'b1;
    chk("rst_ack", 32'(bus.wb_ack_o), 32'd0);
    chk("rst_dat", 32'(bus.wb_dat_o), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_err", 32'({bus.wb_err_o, bus.wb_rty_o}), 32'd0);
    cycles(4);
    chk("rst_pins_lo", 32'(gpio[3:0]), 32'h5);
    wb_read(8'h04, 8'h0F, "rst_ddr");
    wb_read(8'h0C, 8'h00, "arm_ifr");
    wb_read(8'h00, 8'hF5, "rst_datar");

    // Atomic set/clear/toggle with pins looped back.
    wb_write(8'h10, 8'hFF, "cfg_itype");
    tb_oe = 8'h00;
    wb_write(8'h04, 8'hFF, "ddr_out");
    wb_write(8'h00, 8'hF0, "datar_f0");
    wb_write(8'h20, 8'h03, "set03");
    wb_write(8'h24, 8'h10, "clr10");
    wb_write(8'h28, 8'h81, "tgl81");
    cycles(4);
    wb_read(8'h00, 8'h62, "atomic_rb");
    wb_read(8'h20, 8'h00, "set_reads0");

    // Edge interrupts: pin0 rising, pin1 any edge.
    tb_val = 8'h62; tb_oe = 8'hFF;
    wb_write(8'h04, 8'h00, "ddr_in");
    wb_write(8'h14, 8'h01, "ipol01");
    wb_write(8'h18, 8'h02, "iany02");
    wb_write(8'h08, 8'h03, "imr03");
    cycles(4);
    wb_write(8'h0C, 8'hFF, "w1c_all");
    wb_read(8'h0C, 8'h00, "edge_clean");
    chk("edge_irq0", 32'(irq), 32'd0);
    tb_val[0] = 1'b1;
    cycles(2);
    chk("rise_irq_early", 32'(irq), 32'd0);
    cycles(1);
    chk("rise_irq", 32'(irq), 32'd1);
    wb_read(8'h0C, 8'h01, "rise_ifr");
    tb_val[1] = 1'b0;
    cycles(4);
    wb_read(8'h0C, 8'h03, "fall_any_ifr");
    wb_write(8'h0C, 8'h01, "w1c_b0");
    wb_read(8'h0C, 8'h02, "w1c_b0_ifr");
    chk("w1c_b0_irq", 32'(irq), 32'd1);
    tb_val[0] = 1'b0;
    cycles(4);
    wb_read(8'h0C, 8'h02, "fall_b0_noset");
    wb_write(8'h08, 8'h00, "imr00");
    chk("mask_irq", 32'(irq), 32'd0);
    wb_read(8'h0C, 8'h02, "mask_keeps_ifr");

    // Level-low interrupt on pin2.
    tb_val = 8'hFB;
    cycles(4);
    wb_write(8'h14, 8'h00, "ipol00");
    wb_write(8'h18, 8'h00, "iany00");
    wb_write(8'h10, 8'h00, "itype00");
    wb_write(8'h08, 8'h04, "imr04");
    wb_write(8'h0C, 8'hFF, "w1c_lvl");
    cycles(2);
    wb_read(8'h0C, 8'h04, "lvl_ifr");
    chk("lvl_irq", 32'(irq), 32'd1);
    wb_write(8'h0C, 8'h04, "lvl_w1c");
    chk("lvl_w1c_clr", 32'(irq_at_ack), 32'd0);
    chk("lvl_reset", 32'(irq), 32'd1);
    tb_val = 8'hFF;
    cycles(4);
    wb_write(8'h0C, 8'h04, "lvl_w1c2");
    wb_read(8'h0C, 8'h00, "lvl_gone_ifr");
    chk("lvl_gone_irq", 32'(irq), 32'd0);

    // Rising edge on pin0 lands on the same edge as a W1C of bit 0.
    wb_write(8'h10, 8'hFF, "itype_ff");
    wb_write(8'h14, 8'h01, "ipol01b");
    wb_write(8'h08, 8'h01, "imr01");
    tb_val = 8'hFE;
    cycles(4);
    wb_write(8'h0C, 8'hFF, "w1c_sim0");
    wb_read(8'h0C, 8'h00, "sim_clean");
    tb_val[0] = 1'b1;
    cycles(2);
    wb_write(8'h0C, 8'h01, "w1c_sim");
    wb_read(8'h0C, 8'h01, "sim_set_wins");
    chk("sim_irq", 32'(irq), 32'd1);

    // Inversion affects readback but not detection.
    tb_val = 8'hA4;
    cycles(4);
    wb_write(8'h0C, 8'hFF, "w1c_inv");
    wb_write(8'h1C, 8'hFF, "inv_ff");
    wb_read(8'h00, 8'h5B, "inv_rd_a4");
    tb_val = 8'hA5;
    cycles(4);
    wb_read(8'h00, 8'h5A, "inv_rd_a5");
    wb_read(8'h0C, 8'h01, "inv_rise_ifr");

    // Undecoded offsets.
    wb_read(8'h2C, 8'h00, "undec_rd");
    wb_write(8'h30, 8'hFF, "undec_wr");
    wb_read(8'h1C, 8'hFF, "undec_inv_kept");
    wb_read(8'h08, 8'h01, "undec_imr_kept");

    // Reset asserted in the middle of a DATAR write.
    chk("pre_rst_irq", 32'(irq), 32'd1);
    bus.wb_adr_i = 32'h0; bus.wb_we_i = 1'b1; bus.wb_dat_i = 8'hFF;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    #2 wb_rst = 1'b1;
    #1;
    chk("mid_rst_ack", 32'(bus.wb_ack_o), 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    tb_oe = 8'hF0;
    cycles(2);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    wb_rst = 1'b0;
    cycles(4);
    chk("post_rst_pins_lo", 32'(gpio[3:0]), 32'h5);
    wb_read(8'h04, 8'h0F, "post_rst_ddr");
    wb_read(8'h1C, 8'h00, "post_rst_inv");
    wb_read(8'h08, 8'h00, "post_rst_imr");
    wb_read(8'h00, 8'hA5, "post_rst_datar");
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
